// File: rtl/legv8_mem_pkg.sv
// Shared definitions for the LEGv8 multi-cycle data-memory responder:
// FSM state encoding, word geometry and the request address check.
package legv8_mem_pkg;

  localparam int DATA_W     = 64;
  localparam int WORD_BYTES = 8;
  localparam int ADDR_LSB   = $clog2(WORD_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  // A byte address is usable when it is word aligned and falls inside the array.
  function automatic logic addr_ok(input logic [63:0] addr, input int unsigned depth_words);
    return (addr[ADDR_LSB-1:0] == '0) && ((addr >> ADDR_LSB) < 64'(depth_words));
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// DEPTH_WORDS x 64-bit register array: synchronous write, registered read
// with a synchronous clear, and asynchronous clear of every word on reset.
module data_mem_array
  import legv8_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 32,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [AW-1:0]     i_addr,
  input  logic              i_we,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic              i_rclr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH_WORDS];
  logic [DATA_W-1:0] r_rdata;

  // i_rclr wins over i_re so a rejected request leaves zero on the read port.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        r_mem[i] <= '0;
      end
      r_rdata <= '0;
    end else begin
      if (i_we) begin
        r_mem[i_addr] <= i_wdata;
      end
      if (i_rclr) begin
        r_rdata <= '0;
      end else if (i_re) begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: latches a core request, waits LATENCY
// edges, performs the access on the array and pulses mem_ready (and mem_error).
module data_mem_responder
  import legv8_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 32,
  parameter int LATENCY     = 2
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic [63:0]       mem_address,
  input  logic [DATA_W-1:0] mem_data_in,
  input  logic              control_memwrite,
  input  logic              control_memread,
  output logic [DATA_W-1:0] mem_data_out,
  output logic              mem_ready,
  output logic              mem_busy,
  output logic              mem_error,
  output mem_state_e        o_dbg_state
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  // Handshake: a request is sampled only in IDLE; once captured, the request
  // inputs are ignored until the DONE cycle, where mem_ready pulses for one
  // cycle. The DONE->IDLE edge never captures, so a held request re-issues.
  mem_state_e        r_state;
  mem_state_e        w_state_nx;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_nx;
  logic [AW-1:0]     r_idx;
  logic [DATA_W-1:0] r_wdata;
  logic              r_is_write;
  logic              r_valid;
  logic              r_ready;
  logic              r_busy;
  logic              r_error;

  logic w_req;
  logic w_req_valid;
  logic w_capture;
  logic w_access;
  logic w_we;
  logic w_re;
  logic w_rclr;

  assign w_req       = control_memread | control_memwrite;
  assign w_req_valid = (control_memread ^ control_memwrite) && addr_ok(mem_address, DEPTH_WORDS);

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_capture  = 1'b0;
    w_access   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_capture  = 1'b1;
          w_cnt_nx   = CNT_LOAD;
          w_state_nx = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (r_cnt == '0) begin
          w_access   = 1'b1;
          w_state_nx = ST_DONE;
        end else begin
          w_cnt_nx = r_cnt - 1'b1;
        end
      end
      ST_DONE: begin
        w_state_nx = ST_IDLE;
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_wdata    <= '0;
      r_is_write <= 1'b0;
      r_valid    <= 1'b0;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      if (w_capture) begin
        r_idx      <= mem_address[AW+ADDR_LSB-1:ADDR_LSB];
        r_wdata    <= mem_data_in;
        r_is_write <= control_memwrite;
        r_valid    <= w_req_valid;
      end
      // Status flags are registered from the next state, so they track it exactly.
      r_busy  <= (w_state_nx != ST_IDLE);
      r_ready <= (w_state_nx == ST_DONE);
      r_error <= w_access & ~r_valid;
    end
  end

  assign w_we   = w_access & r_valid & r_is_write;
  assign w_re   = w_access & r_valid & ~r_is_write;
  assign w_rclr = w_access & ~r_valid;

  data_mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .i_clk   (CLOCK),
    .i_rst_n (RESET),
    .i_addr  (r_idx),
    .i_we    (w_we),
    .i_wdata (r_wdata),
    .i_re    (w_re),
    .i_rclr  (w_rclr),
    .o_rdata (mem_data_out)
  );

  assign mem_ready   = r_ready;
  assign mem_busy    = r_busy;
  assign mem_error   = r_error;
  assign o_dbg_state = r_state;

endmodule
